// File: rtl/nyancat_frame_loader.sv
// Frame store writer: unpacks a 2-char/byte stream into the back bank of a
// double-buffered frame memory and swaps banks on vsync after a full load.
module nyancat_frame_loader #(
  parameter int NUM_FRAMES = 12,
  parameter int FRAME_W    = 64,
  parameter int FRAME_H    = 64,
  localparam int N         = NUM_FRAMES * FRAME_W * FRAME_H,
  localparam int ADDR_W    = $clog2(N)
) (
  input  logic              px_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  input  logic              vsync_pulse,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [3:0]        wr_data,
  output logic              disp_bank,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WR_LO,
    DRAIN,
    WAIT_VS
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_HI = ADDR_W'(N - 2);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] naddr_q, naddr_d;
  logic [3:0]        lo_q, lo_d;
  logic              last_q, last_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [3:0]        wr_data_q, wr_data_d;
  logic              disp_q, disp_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      naddr_q   <= '0;
      lo_q      <= '0;
      last_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      disp_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      naddr_q   <= naddr_d;
      lo_q      <= lo_d;
      last_q    <= last_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      disp_q    <= disp_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    naddr_d   = naddr_q;
    lo_d      = lo_q;
    last_d    = last_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    disp_d    = disp_q;
    done_d    = 1'b0;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RECV;
          naddr_d = '0;
          err_d   = 1'b0;
        end
      end
      RECV: begin
        if (s_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = naddr_q;
          wr_data_d = s_data[7:4];
          lo_d      = s_data[3:0];
          last_d    = s_last;
          state_d   = WR_LO;
        end
      end
      WR_LO: begin
        wr_en_d   = 1'b1;
        wr_addr_d = naddr_q + ADDR_W'(1);
        wr_data_d = lo_q;
        naddr_d   = naddr_q + ADDR_W'(2);
        // length is judged against the high-nibble address of this byte
        if (last_q && naddr_q == LAST_HI) begin
          state_d = WAIT_VS;
        end else if (last_q) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (naddr_q == LAST_HI) begin
          err_d   = 1'b1;
          state_d = DRAIN;
        end else begin
          state_d = RECV;
        end
      end
      DRAIN: begin
        if (s_valid && s_last) state_d = IDLE;
      end
      WAIT_VS: begin
        if (vsync_pulse) begin
          disp_d  = ~disp_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_ready   = (state_q == RECV) || (state_q == DRAIN);
  assign busy      = (state_q != IDLE);
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign disp_bank = disp_q;
  assign wr_bank   = ~disp_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_nyancat_frame_loader.sv
// Bench for nyancat_frame_loader: random byte streams, scoreboard of
// expected memory writes, checks of error, swap and reset behaviour.
module tb_nyancat_frame_loader;

  localparam int NF = 4;
  localparam int FW = 8;
  localparam int FH = 8;
  localparam int N  = NF * FW * FH;
  localparam int AW = $clog2(N);
  localparam int NB = N / 2;

  logic          px_clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [7:0]    s_data = '0;
  logic          s_last = 1'b0;
  logic          vsync_pulse = 1'b0;
  logic          wr_en;
  logic          wr_bank;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_data;
  logic          disp_bank;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  int wr_base;
  bit model_disp = 1'b0;
  logic [AW+4:0] exp_q[$];

  always #5 px_clk = ~px_clk;

  nyancat_frame_loader #(
    .NUM_FRAMES(NF),
    .FRAME_W(FW),
    .FRAME_H(FH)
  ) dut (
    .px_clk(px_clk),
    .reset(reset),
    .start(start),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_last(s_last),
    .vsync_pulse(vsync_pulse),
    .wr_en(wr_en),
    .wr_bank(wr_bank),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .disp_bank(disp_bank),
    .busy(busy),
    .done(done),
    .err(err)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // monitor: every write must match the head of the expected queue
  always @(negedge px_clk) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (wr_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%0h required=none",
                   {wr_bank, wr_addr, wr_data});
        end else begin
          chk("write", {wr_bank, wr_addr, wr_data}, exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_start();
    @(negedge px_clk);
    start = 1'b1;
    @(negedge px_clk);
    start = 1'b0;
  endtask

  task automatic do_vsync();
    @(negedge px_clk);
    vsync_pulse = 1'b1;
    @(negedge px_clk);
    vsync_pulse = 1'b0;
    repeat (2) @(negedge px_clk);
  endtask

  // Streams nbytes; bytes past NB are expected to be discarded.
  task automatic load(int nbytes, bit gapped, bit seq, bit vs_final,
                      int abort_at);
    int k = 0;
    int cyc = 0;
    bit prev_hs = 1'b0;
    logic [7:0] b;
    b = seq ? 8'(k) : 8'($urandom);
    while (k < nbytes) begin
      @(negedge px_clk);
      if (prev_hs) chk("ready_gap", s_ready, 0);
      prev_hs = 1'b0;
      if (cyc++ > 20 * nbytes + 50) begin
        checks++;
        errors++;
        $display("FAIL timeout actual=%0d required=%0d", k, nbytes);
        break;
      end
      s_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data = b;
      s_last = (k == nbytes - 1);
      if (s_valid && s_ready) begin
        if (k < NB) begin
          exp_q.push_back({~model_disp, AW'(2 * k), b[7:4]});
          exp_q.push_back({~model_disp, AW'(2 * k + 1), b[3:0]});
          prev_hs = 1'b1;
        end
        k++;
        b = seq ? 8'(k) : 8'($urandom);
        if (abort_at > 0 && k == abort_at) return;
      end
    end
    @(negedge px_clk);
    s_valid = 1'b0;
    s_last = 1'b0;
    vsync_pulse = vs_final;
    chk("ready_after_last", s_ready, 0);
    @(negedge px_clk);
    vsync_pulse = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge px_clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_disp", disp_bank, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", s_ready, 0);
    reset = 1'b0;

    // full load, contiguous stream
    wr_base = wr_cnt;
    do_start();
    load(NB, 1'b0, 1'b1, 1'b0, 0);
    repeat (4) @(negedge px_clk);
    chk("t1_queue", exp_q.size(), 0);
    chk("t1_writes", wr_cnt - wr_base, N);
    chk("t1_disp_pre", disp_bank, 0);
    chk("t1_busy_pre", busy, 1);
    chk("t1_err", err, 0);
    chk("t1_done_pre", done_cnt, 0);
    do_vsync();
    model_disp = 1'b1;
    chk("t1_disp", disp_bank, 1);
    chk("t1_done", done_cnt, 1);
    chk("t1_busy", busy, 0);

    // gapped load, vsync coincident with final WR_LO, start while busy
    wr_base = wr_cnt;
    do_start();
    load(NB, 1'b1, 1'b0, 1'b1, 0);
    repeat (6) @(negedge px_clk);
    chk("t2_writes", wr_cnt - wr_base, N);
    chk("t6_disp_hold", disp_bank, 1);
    chk("t6_done_hold", done_cnt, 1);
    chk("t6_busy_hold", busy, 1);
    do_start();
    repeat (3) @(negedge px_clk);
    chk("t6_busy_start", busy, 1);
    chk("t6_no_write", wr_cnt - wr_base, N);
    do_vsync();
    model_disp = 1'b0;
    chk("t6_disp", disp_bank, 0);
    chk("t6_done", done_cnt, 2);
    chk("t6_busy", busy, 0);

    // short load
    wr_base = wr_cnt;
    do_start();
    load(100, 1'b1, 1'b0, 1'b0, 0);
    repeat (4) @(negedge px_clk);
    chk("t3_queue", exp_q.size(), 0);
    chk("t3_writes", wr_cnt - wr_base, 200);
    chk("t3_err", err, 1);
    chk("t3_busy", busy, 0);
    chk("t3_disp", disp_bank, 0);
    do_vsync();
    chk("t3_done", done_cnt, 2);

    // long load
    wr_base = wr_cnt;
    do_start();
    chk("t4_err_clr", err, 0);
    load(NB + 4, 1'b0, 1'b0, 1'b0, 0);
    repeat (4) @(negedge px_clk);
    chk("t4_queue", exp_q.size(), 0);
    chk("t4_writes", wr_cnt - wr_base, N);
    chk("t4_err", err, 1);
    chk("t4_busy", busy, 0);
    do_vsync();
    chk("t4_disp", disp_bank, 0);
    chk("t4_done", done_cnt, 2);

    // swap, then reset in the middle of the following load
    do_start();
    load(NB, 1'b0, 1'b0, 1'b0, 0);
    do_vsync();
    model_disp = 1'b1;
    chk("t5_disp_swap", disp_bank, 1);
    do_start();
    load(NB, 1'b0, 1'b0, 1'b0, 50);
    @(posedge px_clk);
    #2;
    reset = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    #1;
    chk("t5_wr_en", wr_en, 0);
    chk("t5_busy", busy, 0);
    chk("t5_disp", disp_bank, 0);
    chk("t5_done", done, 0);
    chk("t5_err", err, 0);
    chk("t5_ready", s_ready, 0);
    exp_q.delete();
    model_disp = 1'b0;
    repeat (2) @(negedge px_clk);
    reset = 1'b0;
    wr_base = wr_cnt;
    done_cnt = 0;
    do_start();
    load(NB, 1'b1, 1'b0, 1'b0, 0);
    repeat (4) @(negedge px_clk);
    chk("t5_queue", exp_q.size(), 0);
    chk("t5_writes", wr_cnt - wr_base, N);
    chk("t5_err_ok", err, 0);
    do_vsync();
    chk("t5_disp_new", disp_bank, 1);
    chk("t5_done_new", done_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
